// File: rtl/mem_bus_arb_if.sv
// Requester-side handshake, strobes and status of the two-master memory bus arbiter.
// The shared data_io pin stays a plain inout port on the arbiter.
interface mem_bus_arb_if;
    logic        w_req, r_req;
    logic        w_gnt, r_gnt;
    logic [16:0] w_addr, r_addr;
    logic        w_ce, w_oe, w_we;
    logic        r_ce, r_oe, r_we;
    logic [7:0]  w_dout;
    logic        w_drv;
    logic [7:0]  din;
    logic [16:0] addr;
    logic        nce, noe, nwe;
    logic [1:0]  owner;
    logic        busy;
    logic        w_tmo, r_tmo;
    logic        clr_tmo;

    modport slave (
        input  w_req, r_req, w_addr, r_addr, w_ce, w_oe, w_we,
               r_ce, r_oe, r_we, w_dout, w_drv, clr_tmo,
        output w_gnt, r_gnt, din, addr, nce, noe, nwe, owner, busy,
               w_tmo, r_tmo
    );

    modport master (
        output w_req, r_req, w_addr, r_addr, w_ce, w_oe, w_we,
               r_ce, r_oe, r_we, w_dout, w_drv, clr_tmo,
        input  w_gnt, r_gnt, din, addr, nce, noe, nwe, owner, busy,
               w_tmo, r_tmo
    );
endinterface

// File: rtl/mem_bus_arb.sv
// Round-robin arbiter giving a page writer and a readback reader exclusive use of
// an external async SRAM, with bus turnaround gaps and a per-owner hold timeout.
module mem_bus_arb #(
    parameter int TIMEOUT_CYC = 4095,
    parameter int TURN_CYC    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_bus_arb_if.slave bus,
    inout  wire  [7:0]   data_io
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TURN  = 2'd1;
    localparam logic [1:0] OWN_W = 2'd2;
    localparam logic [1:0] OWN_R = 2'd3;

    logic [1:0]  state;
    logic [2:0]  turn_cnt;
    logic [11:0] hold_cnt;
    logic        last_r;
    logic        lock_w, lock_r;
    logic        w_tmo_q, r_tmo_q;
    logic [7:0]  din_q;

    logic own_w, own_r, cur_req, tmo_hit;
    logic w_ok, r_ok, pick_w;

    assign own_w   = (state == OWN_W);
    assign own_r   = (state == OWN_R);
    assign cur_req = own_w ? bus.w_req : bus.r_req;
    // A release in the same cycle as the limit is a normal release, not a timeout.
    assign tmo_hit = (own_w | own_r) & cur_req &
                     ((hold_cnt + 12'd1) == 12'(TIMEOUT_CYC));

    assign w_ok   = bus.w_req & ~lock_w;
    assign r_ok   = bus.r_req & ~lock_r;
    assign pick_w = w_ok & (~r_ok | last_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            turn_cnt <= '0;
            hold_cnt <= '0;
            last_r   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (w_ok | r_ok) begin
                        state    <= pick_w ? OWN_W : OWN_R;
                        hold_cnt <= '0;
                        last_r   <= ~pick_w;
                    end
                end
                TURN: begin
                    if (turn_cnt == 3'(TURN_CYC - 1)) state <= IDLE;
                    else                               turn_cnt <= turn_cnt + 3'd1;
                end
                default: begin
                    if (!cur_req || tmo_hit) begin
                        state    <= TURN;
                        turn_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 12'd1;
                    end
                end
            endcase
        end
    end

    // Lockout holds off a timed-out requester until it lets go of req once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_w  <= 1'b0;
            lock_r  <= 1'b0;
            w_tmo_q <= 1'b0;
            r_tmo_q <= 1'b0;
        end else begin
            lock_w  <= (tmo_hit & own_w) | (lock_w & bus.w_req);
            lock_r  <= (tmo_hit & own_r) | (lock_r & bus.r_req);
            w_tmo_q <= (tmo_hit & own_w) | (w_tmo_q & ~bus.clr_tmo);
            r_tmo_q <= (tmo_hit & own_r) | (r_tmo_q & ~bus.clr_tmo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= '0;
        else        din_q <= data_io;
    end

    assign bus.w_gnt = own_w & bus.w_req;
    assign bus.r_gnt = own_r & bus.r_req;
    assign bus.owner = {own_r, own_w};
    assign bus.busy  = (state != IDLE);
    assign bus.din   = din_q;
    assign bus.w_tmo = w_tmo_q;
    assign bus.r_tmo = r_tmo_q;

    // The reader can never pulse nwe, whatever it puts on r_we.
    always_comb begin
        bus.addr = '0;
        bus.nce  = 1'b1;
        bus.noe  = 1'b1;
        bus.nwe  = 1'b1;
        if (own_w) begin
            bus.addr = bus.w_addr;
            bus.nce  = ~bus.w_ce;
            bus.noe  = ~bus.w_oe;
            bus.nwe  = ~bus.w_we;
        end else if (own_r) begin
            bus.addr = bus.r_addr;
            bus.nce  = ~bus.r_ce;
            bus.noe  = ~bus.r_oe;
        end
    end

    assign data_io = (own_w & bus.w_drv) ? bus.w_dout : 8'hzz;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Randomized and directed bench for mem_bus_arb, checked every cycle against a
// cycle-level behavioural model of owner / turnaround / timeout rules.
module tb_mem_bus_arb;
    localparam int TMO  = 12;
    localparam int TURN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arb_if bi ();
    wire  [7:0] data_io;
    logic       tb_drv;
    logic [7:0] tb_pat;
    assign data_io = tb_drv ? tb_pat : 8'hzz;

    mem_bus_arb #(.TIMEOUT_CYC(TMO), .TURN_CYC(TURN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bi), .data_io(data_io)
    );

    int total = 0;
    int bad   = 0;

    // model: owner 0 none / 1 writer / 2 reader, remaining turnaround cycles
    int         m_own, m_turn, m_hold, m_last;
    bit         m_lock_w, m_lock_r, m_tmo_w, m_tmo_r;
    logic [7:0] m_din;
    bit         force_r_rw;
    bit         clr_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_turn = 0; m_hold = 0; m_last = 2;
        m_lock_w = 0; m_lock_r = 0; m_tmo_w = 0; m_tmo_r = 0;
        m_din = 8'h00;
    endtask

    task automatic rnd_inputs(input bit wr, input bit rr);
        bi.w_req  = wr;
        bi.r_req  = rr;
        bi.w_addr = 17'($urandom);
        bi.r_addr = 17'($urandom);
        bi.w_ce   = 1'($urandom); bi.w_oe = 1'($urandom); bi.w_we = 1'($urandom);
        bi.r_ce   = 1'($urandom); bi.r_oe = 1'($urandom); bi.r_we = 1'($urandom);
        if (force_r_rw) begin bi.r_oe = 1'b1; bi.r_we = 1'b1; bi.r_ce = 1'b1; end
        bi.w_dout = 8'($urandom);
        bi.w_drv  = 1'($urandom);
        bi.clr_tmo = clr_en && ($urandom_range(0, 15) == 0);
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        bit exp_drv, wq, rq, clr, set_w, set_r, cw, cr, rx;
        logic [7:0]  exp_bus;
        logic [16:0] ea;
        logic        ece, eoe, ewe;
        int          pick;
        wq = bi.w_req; rq = bi.r_req; clr = bi.clr_tmo;
        exp_drv = (m_own == 1) && bi.w_drv;
        tb_pat  = 8'($urandom) & 8'hFE;
        if (!exp_drv) bi.w_dout = ~tb_pat;
        tb_drv  = !exp_drv;
        exp_bus = exp_drv ? bi.w_dout : tb_pat;
        #1;
        ea = '0; ece = 1'b1; eoe = 1'b1; ewe = 1'b1;
        if (m_own == 1) begin
            ea = bi.w_addr; ece = ~bi.w_ce; eoe = ~bi.w_oe; ewe = ~bi.w_we;
        end else if (m_own == 2) begin
            ea = bi.r_addr; ece = ~bi.r_ce; eoe = ~bi.r_oe;
        end
        chk("w_gnt", 32'(bi.w_gnt), 32'(m_own == 1 && wq));
        chk("r_gnt", 32'(bi.r_gnt), 32'(m_own == 2 && rq));
        chk("gnt_excl", 32'(bi.w_gnt & bi.r_gnt), 32'd0);
        chk("owner", 32'(bi.owner), 32'(m_own));
        chk("busy", 32'(bi.busy), 32'(m_own != 0 || m_turn != 0));
        chk("addr", 32'(bi.addr), 32'(ea));
        chk("nce", 32'(bi.nce), 32'(ece));
        chk("noe", 32'(bi.noe), 32'(eoe));
        chk("nwe", 32'(bi.nwe), 32'(ewe));
        chk("data_io", 32'(data_io), 32'(exp_bus));
        chk("din", 32'(bi.din), 32'(m_din));
        chk("w_tmo", 32'(bi.w_tmo), 32'(m_tmo_w));
        chk("r_tmo", 32'(bi.r_tmo), 32'(m_tmo_r));
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            set_w = 0; set_r = 0;
            m_din = exp_bus;
            if (m_own != 0) begin
                rx = (m_own == 1) ? wq : rq;
                if (!rx) begin
                    m_own = 0; m_turn = TURN;
                end else if (m_hold + 1 == TMO) begin
                    if (m_own == 1) set_w = 1; else set_r = 1;
                    m_own = 0; m_turn = TURN;
                end else m_hold++;
            end else if (m_turn > 0) begin
                m_turn--;
            end else begin
                cw = wq && !m_lock_w;
                cr = rq && !m_lock_r;
                pick = 0;
                if (cw && cr) pick = (m_last == 2) ? 1 : 2;
                else if (cw)  pick = 1;
                else if (cr)  pick = 2;
                if (pick != 0) begin m_own = pick; m_hold = 0; m_last = pick; end
            end
            if (set_w) m_lock_w = 1; else if (!wq) m_lock_w = 0;
            if (set_r) m_lock_r = 1; else if (!rq) m_lock_r = 0;
            if (set_w) m_tmo_w = 1; else if (clr) m_tmo_w = 0;
            if (set_r) m_tmo_r = 1; else if (clr) m_tmo_r = 0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit wr, input bit rr);
        for (int i = 0; i < n; i++) begin
            rnd_inputs(wr, rr);
            cycle();
        end
    endtask

    initial begin
        int  w_cnt, r_cnt;
        bit  w_on, r_on;
        force_r_rw = 0; clr_en = 0;
        tb_drv = 1'b1; tb_pat = 8'h00;
        rnd_inputs(0, 0);
        model_reset();
        @(negedge clk);

        // reset state
        run(3, 0, 0);
        rst_n = 1'b1;

        // single writer transaction
        run(11, 1, 0);
        run(5, 0, 0);

        // simultaneous contention, three rounds
        for (int k = 0; k < 3; k++) begin
            run(8, 1, 1);
            run(6, 0, 0);
        end

        // reader may not drive nwe or data_io
        force_r_rw = 1;
        run(8, 0, 1);
        run(4, 0, 0);
        force_r_rw = 0;

        // timeout, lockout, regrant after req toggle, flag clear
        run(20, 1, 0);
        run(1, 0, 0);
        run(6, 1, 0);
        rnd_inputs(0, 0);
        bi.clr_tmo = 1'b1;
        cycle();
        run(4, 0, 0);

        // opposing request during ownership waits for release plus turnaround
        run(3, 1, 0);
        run(5, 1, 1);
        run(10, 0, 1);
        run(4, 0, 0);

        // asynchronous reset during a driving writer grant
        run(4, 1, 0);
        rnd_inputs(1, 0);
        bi.w_drv  = 1'b1;
        bi.w_dout = 8'hA5;
        tb_drv    = 1'b0;
        #2;
        rst_n  = 1'b0;
        tb_pat = 8'h5A;
        tb_drv = 1'b1;
        #1;
        chk("rst_owner", 32'(bi.owner), 32'd0);
        chk("rst_nce", 32'(bi.nce), 32'd1);
        chk("rst_nwe", 32'(bi.nwe), 32'd1);
        chk("rst_w_gnt", 32'(bi.w_gnt), 32'd0);
        chk("rst_data_io", 32'(data_io), 32'h5A);
        model_reset();
        @(negedge clk);
        run(1, 1, 0);
        rst_n = 1'b1;
        run(4, 1, 0);
        run(4, 0, 0);

        // random traffic
        clr_en = 1;
        w_on = 0; r_on = 0; w_cnt = 0; r_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (w_cnt == 0) begin
                w_on  = !w_on;
                w_cnt = w_on ? $urandom_range(1, 20) : $urandom_range(1, 4);
            end
            if (r_cnt == 0) begin
                r_on  = !r_on;
                r_cnt = r_on ? $urandom_range(1, 20) : $urandom_range(1, 4);
            end
            w_cnt--; r_cnt--;
            rnd_inputs(w_on, r_on);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
